// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Serialises one character per accepted tx_valid/tx_ready handshake into an
//   asynchronous serial frame: start bit, 5..8 data bits (LSB or MSB first),
//   optional even/odd parity, and 1, 1.5 or 2 stop bits.
//   The bit period is baudrate_divisor * oversampling_bits pclk cycles.
//
// Ports
//   pclk, areset       clock, asynchronous active-low reset
//   baudrate_divisor   pclk cycles per oversample tick
//   oversampling_bits  ticks per bit (2/4/6/8)
//   uart_type          data bits per frame (5..8)
//   stop_bit           0 = 1.5, 1 = 1, 2 = 2 stop bits
//   msb_first          1 = MSB first, 0 = LSB first
//   parity_en          parity bit enable
//   parity_type        0 = even, 1 = odd
//   tx_valid/tx_data   character handshake, tx_ready high only in IDLE
//   tx                 serial line (idle high)
//   busy               frame in progress
//   done               one-cycle pulse on the final stop cycle
//   cfg_err            one-cycle pulse after accepting an invalid configuration
module uart_tx_serializer #(
  parameter int unsigned CHAR_LENGTH = 8,
  parameter int unsigned DIV_WIDTH   = 16
) (
  input  logic                   pclk,
  input  logic                   areset,
  input  logic [DIV_WIDTH-1:0]   baudrate_divisor,
  input  logic [3:0]             oversampling_bits,
  input  logic [3:0]             uart_type,
  input  logic [1:0]             stop_bit,
  input  logic                   msb_first,
  input  logic                   parity_en,
  input  logic                   parity_type,
  input  logic                   tx_valid,
  input  logic [CHAR_LENGTH-1:0] tx_data,
  output logic                   tx_ready,
  output logic                   tx,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err
);

  localparam int unsigned PW = DIV_WIDTH + 4;  // full divisor * oversampling product
  localparam int unsigned CW = PW + 1;         // room for a two-bit-period stop

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_next;
  logic                   rdy_en;
  logic [PW-1:0]          period_q;
  logic [CW-1:0]          stop_len_q;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          dur;
  logic [3:0]             bit_idx;
  logic [3:0]             nbits_q;
  logic [CHAR_LENGTH-1:0] data_q;
  logic                   msb_q, par_en_q, par_odd_q;
  logic                   cfg_err_q;

  logic                   accept, cfg_ok, last;
  logic [PW-1:0]          period_in;
  logic [CW-1:0]          stop_len_in;
  logic [3:0]             sel;
  logic                   data_bit, par_bit;

  assign accept = tx_valid && tx_ready;

  always_comb begin
    cfg_ok = (baudrate_divisor != '0)
          && (oversampling_bits inside {4'd2, 4'd4, 4'd6, 4'd8})
          && (uart_type >= 4'd5) && (uart_type <= 4'd8)
          && (32'(uart_type) <= CHAR_LENGTH)
          && (stop_bit != 2'd3);
  end

  always_comb begin
    period_in = PW'(baudrate_divisor) * PW'(oversampling_bits);
    case (stop_bit)
      2'd0:    stop_len_in = CW'(period_in) + CW'(period_in >> 1);
      2'd2:    stop_len_in = {period_in, 1'b0};
      default: stop_len_in = CW'(period_in);
    endcase
  end

  // Every state except STOP lasts one bit period; DATA repeats it per bit.
  assign dur  = (state == STOP) ? stop_len_q : CW'(period_q);
  assign last = (cnt == dur - CW'(1));

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (accept && cfg_ok) state_next = START;
      START:  if (last) state_next = DATA;
      DATA:   if (last && (bit_idx == nbits_q - 4'd1))
                state_next = par_en_q ? PARITY : STOP;
      PARITY: if (last) state_next = STOP;
      STOP:   if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      rdy_en     <= 1'b0;
      cnt        <= '0;
      bit_idx    <= '0;
      period_q   <= '0;
      stop_len_q <= '0;
      nbits_q    <= '0;
      data_q     <= '0;
      msb_q      <= 1'b0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      rdy_en    <= 1'b1;
      cfg_err_q <= accept && !cfg_ok;

      if (state == IDLE || last) cnt <= '0;
      else                       cnt <= cnt + CW'(1);

      if (state != DATA) bit_idx <= '0;
      else if (last)     bit_idx <= bit_idx + 4'd1;

      if (accept) begin
        period_q   <= period_in;
        stop_len_q <= stop_len_in;
        nbits_q    <= uart_type;
        data_q     <= tx_data;
        msb_q      <= msb_first;
        par_en_q   <= parity_en;
        par_odd_q  <= parity_type;
      end
    end
  end

  // MSB-first walks the active field downwards from bit nbits-1.
  always_comb begin
    sel      = msb_q ? (nbits_q - 4'd1 - bit_idx) : bit_idx;
    data_bit = 1'b1;
    par_bit  = par_odd_q;
    for (int unsigned i = 0; i < CHAR_LENGTH; i++) begin
      if (sel == 4'(i))     data_bit = data_q[i];
      if (4'(i) < nbits_q)  par_bit  = par_bit ^ data_q[i];
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = data_bit;
      PARITY:  tx = par_bit;
      default: tx = 1'b1;
    endcase
  end

  assign tx_ready = rdy_en && (state == IDLE);
  assign busy     = (state != IDLE);
  assign done     = (state == STOP) && last;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

  logic        pclk = 1'b0;
  logic        areset = 1'b0;
  logic [15:0] baudrate_divisor = 16'd1;
  logic [3:0]  oversampling_bits = 4'd2;
  logic [3:0]  uart_type = 4'd8;
  logic [1:0]  stop_bit = 2'd1;
  logic        msb_first = 1'b0;
  logic        parity_en = 1'b0;
  logic        parity_type = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready, tx, busy, done, cfg_err;

  int checks = 0;
  int errors = 0;

  logic tx_log   [0:255];
  logic done_log [0:255];
  logic busy_log [0:255];
  logic rdy_log  [0:255];
  logic cerr_log [0:255];
  logic exp_tx   [0:255];

  uart_tx_serializer #(.CHAR_LENGTH(8), .DIV_WIDTH(16)) dut (
    .pclk(pclk), .areset(areset),
    .baudrate_divisor(baudrate_divisor), .oversampling_bits(oversampling_bits),
    .uart_type(uart_type), .stop_bit(stop_bit), .msb_first(msb_first),
    .parity_en(parity_en), .parity_type(parity_type),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx(tx), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 pclk = ~pclk;

  task automatic set_cfg(input int div, input int os, input int typ, input int stp,
                         input logic msb, input logic pen, input logic ptype);
    baudrate_divisor  = 16'(div);
    oversampling_bits = 4'(os);
    uart_type         = 4'(typ);
    stop_bit          = 2'(stp);
    msb_first         = msb;
    parity_en         = pen;
    parity_type       = ptype;
  endtask

  task automatic accept_one(input logic [7:0] d);
    @(negedge pclk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge pclk);
    #1;
    tx_valid = 1'b0;
  endtask

  // Sample j is taken on the (j+1)-th falling edge after the accept edge.
  task automatic capture(input int off, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      tx_log[off+i]   = tx;
      done_log[off+i] = done;
      busy_log[off+i] = busy;
      rdy_log[off+i]  = tx_ready;
      cerr_log[off+i] = cfg_err;
    end
  endtask

  // seq[0] is the start bit, then data bits in wire order, then parity.
  task automatic build_expect(input int off, input logic [15:0] seq, input int nb,
                              input int p, input int sl, output int fin);
    int idx = off;
    for (int k = 0; k < nb; k++)
      for (int c = 0; c < p; c++) begin
        exp_tx[idx] = seq[k];
        idx++;
      end
    for (int c = 0; c < sl; c++) begin
      exp_tx[idx] = 1'b1;
      idx++;
    end
    fin = idx;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge pclk);
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", tx_ready); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (cfg_err !== 1'b0)  begin errors++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
    areset = 1'b1;
    #1;
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL release_ready_early got %b want 0", tx_ready); end
    @(negedge pclk);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", tx_ready); end
  endtask

  task automatic test_lsb_basic();
    int fin;
    set_cfg(1, 2, 8, 1, 1'b0, 1'b0, 1'b0);
    accept_one(8'hA5);
    capture(0, 22);
    build_expect(0, {7'b0, 8'hA5, 1'b0}, 9, 2, 2, fin);
    for (int j = 0; j < fin; j++) begin
      checks++; if (tx_log[j] !== exp_tx[j]) begin errors++; $display("FAIL basic_tx[%0d] got %b want %b", j, tx_log[j], exp_tx[j]); end
      checks++; if (done_log[j] !== (j == 19)) begin errors++; $display("FAIL basic_done[%0d] got %b want %b", j, done_log[j], (j == 19)); end
      checks++; if (busy_log[j] !== 1'b1) begin errors++; $display("FAIL basic_busy[%0d] got %b want 1", j, busy_log[j]); end
    end
    checks++; if (tx_log[20] !== 1'b1)   begin errors++; $display("FAIL basic_idle_tx got %b want 1", tx_log[20]); end
    checks++; if (busy_log[20] !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b want 0", busy_log[20]); end
    checks++; if (rdy_log[20] !== 1'b1)  begin errors++; $display("FAIL basic_idle_ready got %b want 1", rdy_log[20]); end
  endtask

  task automatic test_msb_parity();
    int fin;
    set_cfg(2, 4, 7, 2, 1'b1, 1'b1, 1'b1);
    accept_one(8'h83);
    capture(0, 90);
    build_expect(0, 16'h01C0, 9, 8, 16, fin);
    for (int j = 0; j < 90; j++) begin
      if (j >= fin) exp_tx[j] = 1'b1;
      checks++; if (tx_log[j] !== exp_tx[j]) begin errors++; $display("FAIL msbpar_tx[%0d] got %b want %b", j, tx_log[j], exp_tx[j]); end
      checks++; if (done_log[j] !== (j == 87)) begin errors++; $display("FAIL msbpar_done[%0d] got %b want %b", j, done_log[j], (j == 87)); end
    end
  endtask

  task automatic test_stop_half();
    int fin;
    set_cfg(1, 8, 5, 0, 1'b0, 1'b0, 1'b0);
    accept_one(8'hED);
    capture(0, 61);
    build_expect(0, 16'h001A, 6, 8, 12, fin);
    for (int j = 0; j < 61; j++) begin
      if (j >= fin) exp_tx[j] = 1'b1;
      checks++; if (tx_log[j] !== exp_tx[j]) begin errors++; $display("FAIL stop15_p8_tx[%0d] got %b want %b", j, tx_log[j], exp_tx[j]); end
      checks++; if (done_log[j] !== (j == 59)) begin errors++; $display("FAIL stop15_p8_done[%0d] got %b want %b", j, done_log[j], (j == 59)); end
    end
    set_cfg(3, 2, 5, 0, 1'b0, 1'b0, 1'b0);
    accept_one(8'hED);
    capture(0, 46);
    build_expect(0, 16'h001A, 6, 6, 9, fin);
    for (int j = 0; j < 46; j++) begin
      if (j >= fin) exp_tx[j] = 1'b1;
      checks++; if (tx_log[j] !== exp_tx[j]) begin errors++; $display("FAIL stop15_p6_tx[%0d] got %b want %b", j, tx_log[j], exp_tx[j]); end
      checks++; if (done_log[j] !== (j == 44)) begin errors++; $display("FAIL stop15_p6_done[%0d] got %b want %b", j, done_log[j], (j == 44)); end
    end
  endtask

  task automatic test_cfg_err();
    for (int v = 0; v < 2; v++) begin
      if (v == 0) set_cfg(1, 2, 0, 1, 1'b0, 1'b0, 1'b0);
      else        set_cfg(1, 3, 8, 1, 1'b0, 1'b0, 1'b0);
      accept_one(8'h3C);
      capture(0, 8);
      for (int j = 0; j < 8; j++) begin
        checks++; if (cerr_log[j] !== (j == 0)) begin errors++; $display("FAIL cfg_err%0d[%0d] got %b want %b", v, j, cerr_log[j], (j == 0)); end
        checks++; if (tx_log[j] !== 1'b1)   begin errors++; $display("FAIL cfg_tx%0d[%0d] got %b want 1", v, j, tx_log[j]); end
        checks++; if (busy_log[j] !== 1'b0) begin errors++; $display("FAIL cfg_busy%0d[%0d] got %b want 0", v, j, busy_log[j]); end
        checks++; if (rdy_log[j] !== 1'b1)  begin errors++; $display("FAIL cfg_ready%0d[%0d] got %b want 1", v, j, rdy_log[j]); end
      end
    end
  endtask

  task automatic test_abort();
    set_cfg(1, 2, 8, 1, 1'b0, 1'b0, 1'b0);
    accept_one(8'hA5);
    capture(0, 9);
    checks++; if (tx_log[8] !== 1'b0)   begin errors++; $display("FAIL abort_bit3 got %b want 0", tx_log[8]); end
    checks++; if (busy_log[8] !== 1'b1) begin errors++; $display("FAIL abort_busy_pre got %b want 1", busy_log[8]); end
    #2;
    areset = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL abort_tx got %b want 1", tx); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b want 0", tx_ready); end
    for (int j = 0; j < 3; j++) begin
      @(negedge pclk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done[%0d] got %b want 0", j, done); end
      checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL abort_hold_tx[%0d] got %b want 1", j, tx); end
    end
    areset = 1'b1;
    #1;
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL abort_release_early got %b want 0", tx_ready); end
    @(negedge pclk);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL abort_release_ready got %b want 1", tx_ready); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL abort_release_done got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    int fin;
    set_cfg(1, 2, 8, 1, 1'b0, 1'b0, 1'b0);
    @(negedge pclk);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(posedge pclk);
    #1;
    // Mid-frame changes: must not affect frame 1, do apply to frame 2.
    tx_data   = 8'hAA;
    msb_first = 1'b1;
    parity_en = 1'b1;
    capture(0, 25);
    tx_valid = 1'b0;
    capture(25, 20);
    build_expect(0, {7'b0, 8'h55, 1'b0}, 9, 2, 2, fin);
    exp_tx[20] = 1'b1;
    build_expect(21, 16'h00AA, 10, 2, 2, fin);
    exp_tx[43] = 1'b1;
    exp_tx[44] = 1'b1;
    for (int j = 0; j < 45; j++) begin
      checks++; if (tx_log[j] !== exp_tx[j]) begin errors++; $display("FAIL b2b_tx[%0d] got %b want %b", j, tx_log[j], exp_tx[j]); end
      checks++; if (done_log[j] !== (j == 19 || j == 42)) begin errors++; $display("FAIL b2b_done[%0d] got %b want %b", j, done_log[j], (j == 19 || j == 42)); end
      if (j < 43) begin
        checks++; if (rdy_log[j] !== (j == 20)) begin errors++; $display("FAIL b2b_ready[%0d] got %b want %b", j, rdy_log[j], (j == 20)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsb_basic();
    test_msb_parity();
    test_stop_half();
    test_cfg_err();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter CHAR_LENGTH, default 8: maximum character width in bits.
REQ-002 SHALL have parameter DIV_WIDTH, default 16: width of baudrate_divisor.
REQ-003 SHALL have port pclk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port areset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port baudrate_divisor, input, DIV_WIDTH bits: pclk cycles per oversample tick.
REQ-006 SHALL have port oversampling_bits, input, 4 bits: ticks per bit (2/4/6/8; 0 invalid).
REQ-007 SHALL have port uart_type, input, 4 bits: data bits per frame (5..8; 0 = no transfer).
REQ-008 SHALL have port stop_bit, input, 2 bits: 1 = one stop bit, 0 = one-and-half stop bits, 2 = two stop bits.
REQ-009 SHALL have port msb_first, input, 1 bit: 1 = MSB shifted first, 0 = LSB first.
REQ-010 SHALL have port parity_en, input, 1 bit; and port parity_type, input, 1 bit: 0 = even, 1 = odd.
REQ-011 SHALL have port tx_valid, input, 1 bit; port tx_data, input, CHAR_LENGTH bits; port tx_ready, output, 1 bit.
REQ-012 SHALL have port tx, output, 1 bit (serial line, idle high); port busy, output, 1 bit; port done, output, 1 bit (one-cycle pulse); port cfg_err, output, 1 bit (one-cycle pulse).

Function
REQ-013 SHALL compute bit period P = baudrate_divisor * oversampling_bits pclk cycles, at full product width, with no truncation.
REQ-014 SHALL accept a character on the cycle where tx_valid and tx_ready are both 1.
- On accept: latch tx_data and all configuration inputs.
- The frame uses only latched values; input changes mid-frame have no effect.
REQ-015 SHALL drive tx_ready = 1 only in state IDLE.
REQ-016 SHALL treat a configuration as invalid if any of the following holds at accept:
- baudrate_divisor = 0;
- oversampling_bits not in {2,4,6,8};
- uart_type not in {5,6,7,8};
- stop_bit = 3.
REQ-017 SHALL respond to an invalid configuration at accept by:
- pulsing cfg_err for the accept cycle + 1;
- staying in IDLE with tx high and sending no frame.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on a valid accept.
- START -> DATA after P cycles.
- DATA -> PARITY after uart_type*P cycles when parity_en = 1; DATA -> STOP after uart_type*P cycles when parity_en = 0.
- PARITY -> STOP after P cycles.
- STOP -> IDLE after the stop duration.
REQ-019 SHALL drive tx per state:
- START: tx = 0.
- DATA: tx = latched bits [0..uart_type-1], LSB-first, or [uart_type-1..0] when msb_first = 1; bits at or above uart_type are ignored.
- PARITY: tx = XOR of the data bits sent when even; its inverse when odd.
- STOP and IDLE: tx = 1.
REQ-020 SHALL set the stop duration to P cycles for code 1, 2*P cycles for code 2, and P + floor(P/2) cycles for code 0.
REQ-021 SHALL drive the first START cycle of tx on the cycle after accept, and change tx only at bit boundaries.
REQ-022 SHALL drive busy = 1 in every state except IDLE.
REQ-023 SHALL pulse done for exactly one cycle, coinciding with the STOP -> IDLE transition.
- tx_ready rises the following cycle, so back-to-back frames have zero idle bit time beyond one pclk.
REQ-024 SHALL abort on areset assertion mid-frame: immediate return to IDLE with tx = 1, and no done pulse.

Reset
REQ-025 SHALL hold the following while areset = 0: state IDLE, tx = 1, tx_ready = 0, busy = 0, done = 0, cfg_err = 0, and all counters and latches cleared.
REQ-026 SHALL raise tx_ready the first pclk edge after areset deasserts.

Verification
REQ-027 SHALL cover: divisor = 1, oversampling = 2, type = 8, LSB first, no parity, stop = 1, data = 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1; each bit held 2 cycles; done pulses after 20 cycles.
REQ-028 SHALL cover: divisor = 2, oversampling = 4, type = 7, MSB first, odd parity, stop = 2, data = 0x83 -> data bits 0,0,0,0,0,1,1; parity = 1; each bit held 8 cycles; stop held 16 cycles.
REQ-029 SHALL cover: P = 8, stop code 0 -> stop held 12 cycles; P = 6 -> stop held 9 cycles.
REQ-030 SHALL cover: uart_type = 0 or oversampling = 3 at accept -> cfg_err pulses once, tx stays 1, busy stays 0.
REQ-031 SHALL cover: areset pulsed during DATA bit 3 -> tx = 1 immediately, no done pulse, tx_ready = 1 one cycle after release.
REQ-032 SHALL cover: tx_valid held high across two frames with data 0x55 then 0xAA -> second START begins the cycle after the done-following accept; changing config mid-frame does not alter the first frame.
